// File: rtl/trig_id_tx_pkg.sv
// Shared trigger-link definitions: FSM state encodings and parameter defaults
// common to the transmit and receive ends of the trigger link.
package trig_id_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_TRIG   = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_PARITY = 3'd4,
    ST_GAP    = 3'd5
  } tx_state_t;

  localparam int ID_WIDTH_DEF  = 16;
  localparam int TRIG_BITS_DEF = 1;
  localparam int GAP_BITS_DEF  = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trig_id_tx_if.sv
// Trigger-ID request handshake: the requester drives id_valid/id_data,
// the transmitter answers with id_ready.
interface trig_id_tx_if
  import trig_id_tx_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF
) ();

  logic                id_valid;
  logic [ID_WIDTH-1:0] id_data;
  logic                id_ready;

  modport master (output id_valid, output id_data, input id_ready);
  modport slave  (input id_valid, input id_data, output id_ready);

endinterface

// File: rtl/trig_id_shreg.sv
// Parallel-load, MSB-out shift register with saturating bit counter and a
// running parity of the bits already shifted out.
module trig_id_shreg
  import trig_id_tx_pkg::*;
#(
  parameter int ID_WIDTH = ID_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [ID_WIDTH-1:0] load_data,
  input  logic                shift,
  output logic                bit_out,
  output logic                last
);

  localparam int               CNT_W   = $clog2(ID_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ID_WIDTH);

  logic [ID_WIDTH-1:0] sr;
  logic                par;
  logic [CNT_W-1:0]    cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (load) begin
      sr  <= load_data;
      par <= 1'b0;
    end else if (shift) begin
      sr  <= {sr[ID_WIDTH-2:0], 1'b0};
      par <= par ^ sr[ID_WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (load)  cnt <= '0;
    else if (shift) cnt <= sat_inc(cnt);
  end

  // Once every ID bit has been launched the next bit on the line is the parity.
  assign last    = (cnt == CNT_MAX);
  assign bit_out = last ? par : sr[ID_WIDTH-1];

endmodule

// File: rtl/trig_id_tx.sv
// Trigger-link transmitter: trigger pulse followed by a serial ID, MSB first,
// paced by bit-clock rising-edge strobes. Define TRIG_ID_TX_PARITY_EN to append an even-parity bit.
module trig_id_tx
  import trig_id_tx_pkg::*;
#(
  parameter int ID_WIDTH  = ID_WIDTH_DEF,
  parameter int TRIG_BITS = TRIG_BITS_DEF,
  parameter int GAP_BITS  = GAP_BITS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_rise,
  input  logic         veto,
  trig_id_tx_if.slave  id_if,
  output logic         trig_out,
  output logic         trig_id_out,
  output logic         busy,
  output logic         frame_done,
  output logic         frame_vetoed
);

  localparam int               PER_MAX   = max_int(max_int(TRIG_BITS, GAP_BITS), 1);
  localparam int               PER_W     = $clog2(PER_MAX + 1);
  localparam logic [PER_W-1:0] TRIG_LAST = PER_W'(TRIG_BITS - 1);
  localparam logic [PER_W-1:0] GAP_LAST  = PER_W'(max_int(GAP_BITS, 1) - 1);

  tx_state_t        state;
  logic [PER_W-1:0] per_cnt;
  logic             load;
  logic             shift;
  logic             bit_out;
  logic             last;

  assign load  = (state == ST_IDLE) && id_if.id_valid && id_if.id_ready;
  assign shift = bit_rise && (((state == ST_TRIG) && (per_cnt == TRIG_LAST)) ||
                              ((state == ST_SHIFT) && !last));

  trig_id_shreg #(.ID_WIDTH(ID_WIDTH)) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (id_if.id_data),
    .shift     (shift),
    .bit_out   (bit_out),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      per_cnt        <= '0;
      trig_out       <= 1'b0;
      trig_id_out    <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
      frame_vetoed   <= 1'b0;
      id_if.id_ready <= 1'b1;
    end else begin
      frame_done   <= 1'b0;
      frame_vetoed <= 1'b0;
      case (state)
        // A strobe coinciding with the accept is deliberately not consumed here.
        ST_IDLE: if (load) begin
          state          <= ST_ARM;
          busy           <= 1'b1;
          id_if.id_ready <= 1'b0;
        end
        ST_ARM: if (bit_rise) begin
          per_cnt <= '0;
          if (veto) begin
            frame_vetoed <= 1'b1;
            if (GAP_BITS == 0) begin
              state <= ST_IDLE; busy <= 1'b0; id_if.id_ready <= 1'b1;
            end else state <= ST_GAP;
          end else begin
            trig_out <= 1'b1;
            state    <= ST_TRIG;
          end
        end
        ST_TRIG: if (bit_rise) begin
          if (per_cnt == TRIG_LAST) begin
            trig_out    <= 1'b0;
            trig_id_out <= bit_out;
            per_cnt     <= '0;
            state       <= ST_SHIFT;
          end else per_cnt <= per_cnt + 1'b1;
        end
        ST_SHIFT: if (bit_rise) begin
          if (!last) trig_id_out <= bit_out;
          else begin
`ifdef TRIG_ID_TX_PARITY_EN
            trig_id_out <= bit_out;
            state       <= ST_PARITY;
`else
            trig_id_out <= 1'b0;
            frame_done  <= 1'b1;
            if (GAP_BITS == 0) begin
              state <= ST_IDLE; busy <= 1'b0; id_if.id_ready <= 1'b1;
            end else state <= ST_GAP;
`endif
          end
        end
        ST_PARITY: if (bit_rise) begin
          trig_id_out <= 1'b0;
          frame_done  <= 1'b1;
          if (GAP_BITS == 0) begin
            state <= ST_IDLE; busy <= 1'b0; id_if.id_ready <= 1'b1;
          end else state <= ST_GAP;
        end
        ST_GAP: if (bit_rise) begin
          if (per_cnt == GAP_LAST) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            id_if.id_ready <= 1'b1;
          end else per_cnt <= per_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_id_tx.sv
// Directed bench for trig_id_tx: bit_rise every 4 clk, line sampled mid-bit
// (bit-clock falling edge). Define TRIG_ID_TX_PARITY_EN to expect the parity bit.
module tb_trig_id_tx;

`ifdef TRIG_ID_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 16 + PB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_rise = 1'b0;
  logic veto = 1'b0;
  logic trig_out, trig_id_out, busy, frame_done, frame_vetoed;
  int   ph = 0;
  int   checks = 0;
  int   errors = 0;

  trig_id_tx_if #(.ID_WIDTH(16)) id_if ();

  trig_id_tx #(.ID_WIDTH(16), .TRIG_BITS(1), .GAP_BITS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_rise     (bit_rise),
    .veto         (veto),
    .id_if        (id_if.slave),
    .trig_out     (trig_out),
    .trig_id_out  (trig_id_out),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_vetoed (frame_vetoed)
  );

  always #5 clk = ~clk;

  // Strobe generator: phase 0 is the bit-clock rising edge, phase 2 the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ph = (ph + 1) % 4;
      bit_rise = (ph == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic logic [63:0] exp_ib(input logic [15:0] id, input int start, input int n);
    logic [63:0] v = '0;
    for (int b = 0; b < 16; b++) v[n-1-start-b] = id[15-b];
    if (PB == 1) v[n-1-start-16] = ^id;
    return v;
  endfunction

  function automatic logic [63:0] exp_tr(input int start, input int n);
    logic [63:0] v = '0;
    v[n-1-start] = 1'b1;
    return v;
  endfunction

  task automatic send(input logic [15:0] id, input int phase);
    int w = 0;
    @(negedge clk);
    while (!(ph == phase && id_if.id_ready === 1'b1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout id_ready=%b required 1", id_if.id_ready);
    end
    id_if.id_valid = 1'b1;
    id_if.id_data  = id;
    @(negedge clk);
    id_if.id_valid = 1'b0;
    id_if.id_data  = 16'hDEAD;
  endtask

  task automatic collect(input int n, output logic [63:0] tr, output logic [63:0] ib,
                         output int n_done, output int n_veto, output int t_trig,
                         output int t_done, output int ready_at, output int overlap);
    int cyc = 0;
    int k = 0;
    tr = '0; ib = '0; n_done = 0; n_veto = 0;
    t_trig = -1; t_done = -1; ready_at = -1; overlap = 0;
    while (k < n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_done === 1'b1) begin
        n_done++;
        if (t_done < 0) t_done = cyc;
      end
      if (frame_vetoed === 1'b1) n_veto++;
      if (trig_out === 1'b1 && t_trig < 0) t_trig = cyc;
      if (trig_out === 1'b1 && trig_id_out === 1'b1) overlap++;
      if (ph == 2) begin
        tr = {tr[62:0], trig_out};
        ib = {ib[62:0], trig_id_out};
        if (id_if.id_ready === 1'b1 && ready_at < 0) ready_at = k;
        k++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (trig_out !== 1'b0) begin errors++; $display("FAIL rst_trig_out got %b need 0", trig_out); end
    checks++; if (trig_id_out !== 1'b0) begin errors++; $display("FAIL rst_trig_id_out got %b need 0", trig_id_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b need 0", busy); end
    checks++; if ({frame_done, frame_vetoed} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b need 00", {frame_done, frame_vetoed}); end
    checks++; if (id_if.id_ready !== 1'b1) begin errors++; $display("FAIL rst_id_ready got %b need 1", id_if.id_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    logic [63:0] tr, ib;
    int nd, nv, tt, td, ra, ov;
    int n = FL + 3;
    send(16'hA5C3, 1);
    checks++; if (busy !== 1'b1 || id_if.id_ready !== 1'b0) begin errors++; $display("FAIL accept_flags busy/ready got %b%b need 10", busy, id_if.id_ready); end
    collect(n, tr, ib, nd, nv, tt, td, ra, ov);
    checks++; if (tr !== exp_tr(1, n)) begin errors++; $display("FAIL a5c3_trig got %h need %h", tr, exp_tr(1, n)); end
    checks++; if (ib !== exp_ib(16'hA5C3, 2, n)) begin errors++; $display("FAIL a5c3_id got %h need %h", ib, exp_ib(16'hA5C3, 2, n)); end
    checks++; if (tt !== 3) begin errors++; $display("FAIL a5c3_trig_start got %0d need 3", tt); end
    checks++; if (td - tt !== (1 + FL) * 4) begin errors++; $display("FAIL a5c3_done_time got %0d need %0d", td - tt, (1 + FL) * 4); end
    checks++; if (nd !== 1 || nv !== 0) begin errors++; $display("FAIL a5c3_pulses done=%0d vetoed=%0d need 1,0", nd, nv); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL a5c3_overlap got %0d need 0", ov); end
  endtask

  task automatic test_strobe_on_accept();
    logic [63:0] tr, ib;
    int nd, nv, tt, td, ra, ov;
    int n = FL + 3;
    send(16'hC3A5, 0);
    collect(n, tr, ib, nd, nv, tt, td, ra, ov);
    checks++; if (tr !== exp_tr(1, n)) begin errors++; $display("FAIL same_strobe_trig got %h need %h", tr, exp_tr(1, n)); end
    checks++; if (ib !== exp_ib(16'hC3A5, 2, n)) begin errors++; $display("FAIL same_strobe_id got %h need %h", ib, exp_ib(16'hC3A5, 2, n)); end
  endtask

  task automatic test_loopback();
    logic [63:0] tr, ib;
    logic [15:0] ids [3];
    int nd, nv, tt, td, ra, ov;
    int n = FL + 3;
    ids[0] = 16'h1234; ids[1] = 16'hFFFF; ids[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      send(ids[i], 1);
      fork
        collect(n, tr, ib, nd, nv, tt, td, ra, ov);
        begin
          // Veto mid-frame must not disturb a committed frame.
          if (i == 1) begin
            repeat (12) @(negedge clk);
            veto = 1'b1;
            repeat (20) @(negedge clk);
            veto = 1'b0;
          end
        end
      join
      checks++; if (ib[n-3 -: 16] !== ids[i]) begin errors++; $display("FAIL loopback_id%0d got %h need %h", i, ib[n-3 -: 16], ids[i]); end
      checks++; if (nd !== 1 || nv !== 0 || tr !== exp_tr(1, n)) begin errors++; $display("FAIL loopback_frame%0d done=%0d vetoed=%0d trig=%h", i, nd, nv, tr); end
    end
  endtask

  task automatic test_veto();
    logic [63:0] tr, ib;
    int nd, nv, tt, td, ra, ov;
    veto = 1'b1;
    send(16'h00FF, 1);
    collect(6, tr, ib, nd, nv, tt, td, ra, ov);
    veto = 1'b0;
    checks++; if (nv !== 1) begin errors++; $display("FAIL veto_pulse got %0d need 1", nv); end
    checks++; if (tr !== 64'd0 || ib !== 64'd0) begin errors++; $display("FAIL veto_lines trig=%h id=%h need 0", tr, ib); end
    checks++; if (nd !== 0) begin errors++; $display("FAIL veto_done got %0d need 0", nd); end
    checks++; if (ra !== 3) begin errors++; $display("FAIL veto_ready_at got %0d need 3", ra); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] tr, ib, etr, eib;
    int nd, nv, tt, td, ra, ov;
    int sp = FL + 4;
    int n = 3 * sp;
    int w = 0;
    logic [15:0] ids [3];
    ids[0] = 16'd1; ids[1] = 16'd2; ids[2] = 16'd3;
    etr = '0; eib = '0;
    for (int f = 0; f < 3; f++) begin
      etr = etr | exp_tr(f * sp + 1, n);
      eib = eib | exp_ib(ids[f], f * sp + 2, n);
    end
    @(negedge clk);
    while (!(ph == 1 && id_if.id_ready === 1'b1) && w < 200) begin @(negedge clk); w++; end
    id_if.id_valid = 1'b1;
    id_if.id_data  = ids[0];
    @(posedge clk);
    fork
      collect(n, tr, ib, nd, nv, tt, td, ra, ov);
      begin
        for (int i = 1; i < 3; i++) begin
          int wt = 0;
          @(negedge clk);
          id_if.id_data = ids[i];
          while (id_if.id_ready !== 1'b1 && wt < 200) begin @(negedge clk); wt++; end
          if (wt >= 200) begin
            checks++; errors++;
            $display("FAIL b2b_ready_timeout frame %0d id_ready=%b required 1", i, id_if.id_ready);
          end
          @(posedge clk);
        end
        @(negedge clk);
        id_if.id_valid = 1'b0;
      end
    join
    checks++; if (tr !== etr) begin errors++; $display("FAIL b2b_trig got %h need %h", tr, etr); end
    checks++; if (ib !== eib) begin errors++; $display("FAIL b2b_id got %h need %h", ib, eib); end
    checks++; if (nd !== 3) begin errors++; $display("FAIL b2b_done_count got %0d need 3", nd); end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] tr, ib;
    int nd, nv, tt, td, ra, ov;
    int n = FL + 3;
    int bad = 0;
    send(16'hBEEF, 1);
    repeat (33) @(negedge clk);
    checks++; if (trig_id_out !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL beef_bit7 line=%b busy=%b need 1,1", trig_id_out, busy); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if ({trig_out, trig_id_out, busy, frame_done, frame_vetoed} !== 5'b0) begin errors++; $display("FAIL midrst_outputs got %b need 00000", {trig_out, trig_id_out, busy, frame_done, frame_vetoed}); end
    checks++; if (id_if.id_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b need 1", id_if.id_ready); end
    @(negedge clk);
    reset = 1'b0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1 || trig_out === 1'b1 || trig_id_out === 1'b1) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles need 0", bad); end
    send(16'h1234, 1);
    collect(n, tr, ib, nd, nv, tt, td, ra, ov);
    checks++; if (ib !== exp_ib(16'h1234, 2, n) || nd !== 1) begin errors++; $display("FAIL midrst_resend id=%h done=%0d need %h,1", ib, nd, exp_ib(16'h1234, 2, n)); end
  endtask

  task automatic test_parity();
    logic [63:0] tr, ib;
    int nd, nv, tt, td, ra, ov;
    int n = FL + 3;
    send(16'h0001, 1);
    collect(n, tr, ib, nd, nv, tt, td, ra, ov);
    checks++; if (ib[n-1-18] !== ((PB == 1) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL par_0001_bit17 got %b need %b", ib[n-1-18], (PB == 1)); end
    checks++; if (td - tt !== (1 + FL) * 4) begin errors++; $display("FAIL par_0001_done_time got %0d need %0d", td - tt, (1 + FL) * 4); end
    checks++; if (ib !== exp_ib(16'h0001, 2, n)) begin errors++; $display("FAIL par_0001_id got %h need %h", ib, exp_ib(16'h0001, 2, n)); end
    send(16'h0003, 1);
    collect(n, tr, ib, nd, nv, tt, td, ra, ov);
    checks++; if (ib[n-1-18] !== 1'b0) begin errors++; $display("FAIL par_0003_bit17 got %b need 0", ib[n-1-18]); end
    checks++; if (ib !== exp_ib(16'h0003, 2, n)) begin errors++; $display("FAIL par_0003_id got %h need %h", ib, exp_ib(16'h0003, 2, n)); end
  endtask

  initial begin
    id_if.id_valid = 1'b0;
    id_if.id_data  = 16'h0000;
    test_reset();
    test_basic_frame();
    test_strobe_on_accept();
    test_loopback();
    test_veto();
    test_back_to_back();
    test_reset_mid_frame();
    test_parity();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
